vga_timing_gen: RTL and testbench

Parametrised VGA raster engine that replaces the fixed pixel-clock toggle flop and fixed-timing driver. It derives a pixel clock-enable from CLOCK_50, generates programmable horizontal/vertical timing with selectable sync polarity, and produces registered RGB from four built-in pattern modes. It sits between the board clock and the VGA DAC pins.

---
 rtl/vga_timing_gen_if.sv | 36 +++
 rtl/vga_timing_gen.sv | 263 ++++++++++++++++++++++++++
 tb/tb_vga_timing_gen.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/vga_timing_gen_if.sv
// VGA raster bundle: pattern controls in, DAC pins and raster position/strobes out.
interface vga_timing_gen_if #(
    parameter int unsigned CW = 11
);
    logic [1:0]    mode;
    logic [23:0]   fg_rgb;
    logic          VGA_CLK;
    logic          VGA_BLANK_N;
    logic          VGA_SYNC_N;
    logic          VGA_HS;
    logic          VGA_VS;
    logic [7:0]    VGA_R;
    logic [7:0]    VGA_G;
    logic [7:0]    VGA_B;
    logic [CW-1:0] H_Cont;
    logic [CW-1:0] V_Cont;
    logic          pix_ce;
    logic          line_start;
    logic          frame_start;

    // Raster source side (the timing generator).
    modport master (
        input  mode, fg_rgb,
        output VGA_CLK, VGA_BLANK_N, VGA_SYNC_N, VGA_HS, VGA_VS,
        output VGA_R, VGA_G, VGA_B, H_Cont, V_Cont,
        output pix_ce, line_start, frame_start
    );

    // Consumer side (DAC pins, downstream logic, bench).
    modport slave (
        output mode, fg_rgb,
        input  VGA_CLK, VGA_BLANK_N, VGA_SYNC_N, VGA_HS, VGA_VS,
        input  VGA_R, VGA_G, VGA_B, H_Cont, V_Cont,
        input  pix_ce, line_start, frame_start
    );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster engine: pixel clock-enable divider, programmable h/v timing with
// selectable sync polarity, and a registered RGB stage with four built-in test patterns.
module vga_timing_gen #(
    parameter int unsigned CLK_DIV  = 2,
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter bit          HS_POL   = 1'b0,
    parameter bit          VS_POL   = 1'b0,
    parameter int unsigned CW       = 11,
    parameter int unsigned CHK_LOG2 = 5
) (
    input logic              CLOCK_50,
    input logic              rst,
    vga_timing_gen_if.master vga
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned DW      = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

    localparam logic [DW-1:0] DCNT_LAST  = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] DCNT_HALF  = DW'(CLK_DIV / 2);
    localparam logic [CW-1:0] H_LAST     = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST     = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT      = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT      = CW'(V_ACTIVE);
    localparam logic [CW-1:0] H_SYNC_ON  = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] H_SYNC_OFF = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] V_SYNC_ON  = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] V_SYNC_OFF = CW'(V_ACTIVE + V_FP + V_SYNC);
    // Last in-bar offset of bars 0..6; bar 7 absorbs the H_ACTIVE % 8 remainder.
    localparam logic [CW-1:0] BAR_LAST   = CW'(H_ACTIVE / 8 - 1);

    // Pattern select encodings.
    localparam logic [1:0] ModeSolid    = 2'd0;
    localparam logic [1:0] ModeBars     = 2'd1;
    localparam logic [1:0] ModeChecker  = 2'd2;
    localparam logic [1:0] ModeGradient = 2'd3;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic          run_q;
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic          vga_clk_q, vga_clk_d;
    logic [CW-1:0] h_q, h_d;
    logic [CW-1:0] v_q, v_d;
    logic [CW-1:0] bar_cnt_q, bar_cnt_d;
    logic [2:0]    bar_idx_q, bar_idx_d;
    logic [1:0]    mode_q, mode_d;

    logic          blank_n_q, blank_n_d;
    logic          hs_q, hs_d;
    logic          vs_q, vs_d;
    logic [23:0]   rgb_q, rgb_d;
    logic [CW-1:0] hcont_q, hcont_d;
    logic [CW-1:0] vcont_q, vcont_d;
    logic          ls_q, ls_d;
    logic          fs_q, fs_d;

    // Combinational decode
    logic          pix_ce;
    logic          h_wrap;
    logic          v_wrap;
    logic          active;
    logic          hs_on;
    logic          vs_on;
    logic [23:0]   bar_rgb;
    logic          chk_sel;
    logic [8:0]    grad_sum;
    logic [23:0]   pat_rgb;

    // Reset release is re-timed by one flop so the divider starts cleanly on a clock edge.
    always_ff @(posedge CLOCK_50 or negedge rst) begin
        if (!rst) begin
            run_q <= 1'b0;
        end else begin
            run_q <= 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Pixel divider
    // ------------------------------------------------------------------------
    assign pix_ce = run_q && (dcnt_q == DCNT_LAST);

    // Divider next state; VGA_CLK is low for the first half of each pixel so its rising
    // edge lands mid-pixel while the registered outputs are stable.
    always_comb begin
        dcnt_d = dcnt_q;
        if (run_q) begin
            dcnt_d = pix_ce ? '0 : dcnt_q + 1'b1;
        end
        vga_clk_d = (dcnt_d >= DCNT_HALF);
    end

    // ------------------------------------------------------------------------
    // Raster counters
    // ------------------------------------------------------------------------
    assign h_wrap = (h_q == H_LAST);
    assign v_wrap = (v_q == V_LAST);

    // Horizontal/vertical position, advanced once per pixel.
    always_comb begin
        h_d = h_q;
        v_d = v_q;
        if (pix_ce) begin
            h_d = h_wrap ? '0 : h_q + 1'b1;
            if (h_wrap) begin
                v_d = v_wrap ? '0 : v_q + 1'b1;
            end
        end
    end

    // Bar index tracked alongside h so no divider by H_ACTIVE/8 is needed.
    always_comb begin
        bar_cnt_d = bar_cnt_q;
        bar_idx_d = bar_idx_q;
        if (pix_ce) begin
            if (h_wrap) begin
                bar_cnt_d = '0;
                bar_idx_d = '0;
            end else if (bar_idx_q != 3'd7) begin
                if (bar_cnt_q == BAR_LAST) begin
                    bar_cnt_d = '0;
                    bar_idx_d = bar_idx_q + 3'd1;
                end else begin
                    bar_cnt_d = bar_cnt_q + 1'b1;
                end
            end
        end
    end

    // Pattern select is only taken at the frame boundary so a frame never mixes patterns.
    always_comb begin
        mode_d = mode_q;
        if (pix_ce && h_wrap && v_wrap) begin
            mode_d = vga.mode;
        end
    end

    // ------------------------------------------------------------------------
    // Decode of the current counter position
    // ------------------------------------------------------------------------
    assign active   = (h_q < H_ACT) && (v_q < V_ACT);
    assign hs_on    = (h_q >= H_SYNC_ON) && (h_q < H_SYNC_OFF);
    assign vs_on    = (v_q >= V_SYNC_ON) && (v_q < V_SYNC_OFF);
    assign chk_sel  = h_q[CHK_LOG2] ^ v_q[CHK_LOG2];
    assign grad_sum = {1'b0, h_q[7:0]} + {1'b0, v_q[7:0]};

    // Colour-bar palette, left to right.
    always_comb begin
        bar_rgb = 24'h000000;
        unique case (bar_idx_q)
            3'd0: bar_rgb = 24'hFFFFFF;  // white
            3'd1: bar_rgb = 24'hFFFF00;  // yellow
            3'd2: bar_rgb = 24'h00FFFF;  // cyan
            3'd3: bar_rgb = 24'h00FF00;  // green
            3'd4: bar_rgb = 24'hFF00FF;  // magenta
            3'd5: bar_rgb = 24'hFF0000;  // red
            3'd6: bar_rgb = 24'h0000FF;  // blue
            3'd7: bar_rgb = 24'h000000;  // black
        endcase
    end

    // Pattern generator; blanked pixels are forced black.
    always_comb begin
        pat_rgb = 24'h000000;
        unique case (mode_q)
            ModeSolid:    pat_rgb = vga.fg_rgb;
            ModeBars:     pat_rgb = bar_rgb;
            ModeChecker:  pat_rgb = chk_sel ? vga.fg_rgb : 24'h000000;
            ModeGradient: pat_rgb = {h_q[7:0], v_q[7:0], grad_sum[8:1]};
        endcase
        if (!active) begin
            pat_rgb = 24'h000000;
        end
    end

    // Output stage: everything captured on the same pix_ce from the same counters so all
    // pins and position reports stay mutually aligned, one pixel behind the counters.
    always_comb begin
        blank_n_d = blank_n_q;
        hs_d      = hs_q;
        vs_d      = vs_q;
        rgb_d     = rgb_q;
        hcont_d   = hcont_q;
        vcont_d   = vcont_q;
        ls_d      = ls_q;
        fs_d      = fs_q;
        if (pix_ce) begin
            blank_n_d = active;
            hs_d      = hs_on ? HS_POL : !HS_POL;
            vs_d      = vs_on ? VS_POL : !VS_POL;
            rgb_d     = pat_rgb;
            hcont_d   = h_q;
            vcont_d   = v_q;
            ls_d      = (h_q == '0);
            fs_d      = (h_q == '0) && (v_q == '0);
        end
    end

    // All state registers; reset returns to the idle, deasserted-sync state immediately.
    always_ff @(posedge CLOCK_50 or negedge rst) begin
        if (!rst) begin
            dcnt_q    <= '0;
            vga_clk_q <= 1'b0;
            h_q       <= '0;
            v_q       <= '0;
            bar_cnt_q <= '0;
            bar_idx_q <= '0;
            mode_q    <= ModeSolid;
            blank_n_q <= 1'b0;
            hs_q      <= !HS_POL;
            vs_q      <= !VS_POL;
            rgb_q     <= '0;
            hcont_q   <= '0;
            vcont_q   <= '0;
            ls_q      <= 1'b0;
            fs_q      <= 1'b0;
        end else begin
            dcnt_q    <= dcnt_d;
            vga_clk_q <= vga_clk_d;
            h_q       <= h_d;
            v_q       <= v_d;
            bar_cnt_q <= bar_cnt_d;
            bar_idx_q <= bar_idx_d;
            mode_q    <= mode_d;
            blank_n_q <= blank_n_d;
            hs_q      <= hs_d;
            vs_q      <= vs_d;
            rgb_q     <= rgb_d;
            hcont_q   <= hcont_d;
            vcont_q   <= vcont_d;
            ls_q      <= ls_d;
            fs_q      <= fs_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign vga.VGA_CLK     = vga_clk_q;
    assign vga.VGA_BLANK_N = blank_n_q;
    assign vga.VGA_SYNC_N  = 1'b0;
    assign vga.VGA_HS      = hs_q;
    assign vga.VGA_VS      = vs_q;
    assign vga.VGA_R       = rgb_q[23:16];
    assign vga.VGA_G       = rgb_q[15:8];
    assign vga.VGA_B       = rgb_q[7:0];
    assign vga.H_Cont      = hcont_q;
    assign vga.V_Cont      = vcont_q;
    assign vga.pix_ce      = pix_ce;
    assign vga.line_start  = ls_q;
    assign vga.frame_start = fs_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen on a reduced raster: a pixel-level reference model
// queues expected pixels, a monitor pops and compares whenever the DUT presents a pixel.
module tb_vga_timing_gen;

    localparam int unsigned CLK_DIV  = 3;
    localparam int unsigned HA       = 50;
    localparam int unsigned HFP      = 2;
    localparam int unsigned HSW      = 4;
    localparam int unsigned HBP      = 3;
    localparam int unsigned VA       = 20;
    localparam int unsigned VFP      = 1;
    localparam int unsigned VSW      = 2;
    localparam int unsigned VBP      = 2;
    localparam bit          HS_POL   = 1'b1;
    localparam bit          VS_POL   = 1'b0;
    localparam int unsigned CW       = 11;
    localparam int unsigned CHK      = 2;
    localparam int unsigned H_T      = HA + HFP + HSW + HBP;
    localparam int unsigned V_T      = VA + VFP + VSW + VBP;
    localparam int unsigned FRAME_CLK = H_T * V_T * CLK_DIV;

    typedef struct {
        int unsigned cyc;
        int unsigned h;
        int unsigned v;
        bit          blank_n;
        bit          hs;
        bit          vs;
        bit          ls;
        bit          fs;
        logic [23:0] rgb;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [1:0]  mode_drv;
    logic [23:0] fg_drv;
    bit          running;

    int unsigned n_checks;
    int unsigned n_errors;
    exp_t        sb_q[$];

    int unsigned edge_k;
    int unsigned mcyc;
    bit          prev_pce;
    int unsigned frame_mode;
    int unsigned pend_mode;

    vga_timing_gen_if #(.CW(CW)) vif ();

    assign vif.mode   = mode_drv;
    assign vif.fg_rgb = fg_drv;

    vga_timing_gen #(
        .CLK_DIV (CLK_DIV),
        .H_ACTIVE(HA),
        .H_FP    (HFP),
        .H_SYNC  (HSW),
        .H_BP    (HBP),
        .V_ACTIVE(VA),
        .V_FP    (VFP),
        .V_SYNC  (VSW),
        .V_BP    (VBP),
        .HS_POL  (HS_POL),
        .VS_POL  (VS_POL),
        .CW      (CW),
        .CHK_LOG2(CHK)
    ) dut (
        .CLOCK_50(clk),
        .rst     (rst_n),
        .vga     (vif)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected colour of pixel (h,v) under pattern m.
    function automatic logic [23:0] ref_rgb(int unsigned h, int unsigned v, int unsigned m,
                                            logic [23:0] fg);
        int unsigned b;
        if (h >= HA || v >= VA) return 24'h000000;
        case (m)
            0: return fg;
            1: begin
                b = h / (HA / 8);
                if (b > 7) b = 7;
                case (b)
                    0: return 24'hFFFFFF;
                    1: return 24'hFFFF00;
                    2: return 24'h00FFFF;
                    3: return 24'h00FF00;
                    4: return 24'hFF00FF;
                    5: return 24'hFF0000;
                    6: return 24'h0000FF;
                    default: return 24'h000000;
                endcase
            end
            2: return ((((h >> CHK) ^ (v >> CHK)) & 1) != 0) ? fg : 24'h000000;
            default: return {8'(h % 256), 8'(v % 256), 8'(((h % 256) + (v % 256)) / 2)};
        endcase
    endfunction

    // Reference model: pixel n is captured at clock edge CLK_DIV*(n+1)+1 after release.
    always @(posedge clk) begin : model
        int unsigned n;
        exp_t        e;
        if (running) begin
            edge_k++;
            if (edge_k > CLK_DIV && ((edge_k - 1) % CLK_DIV) == 0) begin
                n = (edge_k - 1) / CLK_DIV - 1;
                e.cyc = edge_k;
                e.h   = n % H_T;
                e.v   = (n / H_T) % V_T;
                if (e.h == 0 && e.v == 0 && n != 0) frame_mode = pend_mode;
                if (e.h == H_T - 1 && e.v == V_T - 1) pend_mode = mode_drv;
                e.blank_n = (e.h < HA) && (e.v < VA);
                e.hs = (e.h >= HA + HFP && e.h < HA + HFP + HSW) ? HS_POL : !HS_POL;
                e.vs = (e.v >= VA + VFP && e.v < VA + VFP + VSW) ? VS_POL : !VS_POL;
                e.ls = (e.h == 0);
                e.fs = (e.h == 0) && (e.v == 0);
                e.rgb = ref_rgb(e.h, e.v, frame_mode, fg_drv);
                sb_q.push_back(e);
            end
        end
    end

    // Random stimulus on the inactive edge: frequent colour changes, occasional mode steps.
    always @(negedge clk) begin
        if (running) begin
            if ($urandom_range(0, 39) == 0) fg_drv = 24'($urandom);
            if ($urandom_range(0, 1199) == 0) mode_drv = mode_drv + 2'd1;
        end
    end

    // Monitor: divider phase every cycle; a new pixel is presented the cycle after pix_ce.
    always @(negedge clk) begin : monitor
        int unsigned phase;
        exp_t        e;
        if (running) begin
            mcyc++;
            phase = (mcyc - 1) % CLK_DIV;
            check("divider_clk_ce", 64'({vif.VGA_CLK, vif.pix_ce}),
                  64'({phase >= CLK_DIV / 2, phase == CLK_DIV - 1}));
            if (prev_pce) begin
                if (sb_q.size() == 0) begin
                    check("pix_unexpected", 64'(mcyc), 64'(0));
                end else begin
                    e = sb_q.pop_front();
                    check("pix_time", 64'(mcyc), 64'(e.cyc));
                    check("pix_hv", 64'({vif.H_Cont, vif.V_Cont}), 64'({CW'(e.h), CW'(e.v)}));
                    check("pix_ctl", 64'({vif.VGA_BLANK_N, vif.VGA_HS, vif.VGA_VS,
                                          vif.line_start, vif.frame_start, vif.VGA_SYNC_N}),
                          64'({e.blank_n, e.hs, e.vs, e.ls, e.fs, 1'b0}));
                    check("pix_rgb", 64'({vif.VGA_R, vif.VGA_G, vif.VGA_B}), 64'(e.rgb));
                end
            end
            prev_pce = vif.pix_ce;
        end
    end

    task automatic check_reset(input string name);
        check({name, "_ctl"}, 64'({vif.VGA_CLK, vif.VGA_BLANK_N, vif.VGA_SYNC_N, vif.VGA_HS,
                                   vif.VGA_VS, vif.pix_ce, vif.line_start, vif.frame_start}),
              64'({1'b0, 1'b0, 1'b0, !HS_POL, !VS_POL, 1'b0, 1'b0, 1'b0}));
        check({name, "_rgb"}, 64'({vif.VGA_R, vif.VGA_G, vif.VGA_B}), 64'(0));
        check({name, "_hv"}, 64'({vif.H_Cont, vif.V_Cont}), 64'(0));
    endtask

    task automatic release_reset();
        @(negedge clk);
        #1;
        edge_k     = 0;
        mcyc       = 0;
        prev_pce   = 1'b0;
        frame_mode = 0;
        pend_mode  = 0;
        sb_q.delete();
        rst_n      = 1'b1;
        running    = 1'b1;
    endtask

    task automatic assert_reset();
        @(negedge clk);
        #1;
        check("sb_drain", 64'(sb_q.size()), 64'(0));
        running = 1'b0;
        rst_n   = 1'b0;
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        running  = 1'b0;
        rst_n    = 1'b0;
        mode_drv = 2'd2;  // nonzero before release: first frame must still be solid
        fg_drv   = 24'h123456;
        repeat (3) @(negedge clk);
        #1 check_reset("reset_init");

        release_reset();
        repeat (5 * FRAME_CLK + $urandom_range(100, 2000)) @(negedge clk);

        // Mid-line asynchronous reset: outputs must drop before any further clock edge.
        assert_reset();
        check_reset("reset_mid");
        repeat (4) @(negedge clk);
        #1 check_reset("reset_hold");

        release_reset();
        repeat (3 * FRAME_CLK + 50) @(negedge clk);
        assert_reset();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
